// File: rtl/exception_unit_if.sv
// CP0 side of the exception interface: cause levels, EPC/BadVAddr out, ack and EPC back in.
// Handshake: the exception unit holds exactly one int_* high (the request) with epc_out and
// badvaddr_out stable until CP0 returns a one-cycle cop_reset pulse (the acknowledge).
interface exception_unit_if;
    logic        int_ext;
    logic        int_tr;
    logic        int_ovf;
    logic        int_ri;
    logic        int_sys;
    logic        int_addrs;
    logic        int_addrl;
    logic [31:0] epc_out;
    logic [31:0] badvaddr_out;
    logic        cop_reset;
    logic [31:0] epc_in;
    logic        exc_level;

    modport master (
        output int_ext, int_tr, int_ovf, int_ri, int_sys, int_addrs, int_addrl,
        output epc_out, badvaddr_out,
        input  cop_reset, epc_in, exc_level
    );

    modport slave (
        input  int_ext, int_tr, int_ovf, int_ri, int_sys, int_addrs, int_addrl,
        input  epc_out, badvaddr_out,
        output cop_reset, epc_in, exc_level
    );
endinterface

// File: rtl/exception_unit.sv
// Selects one exception cause from the commit stage, raises it to CP0, waits for the ack,
// then flushes and redirects fetch; also sequences ERET (flush, redirect to CP0 EPC).
module exception_unit #(
    parameter logic [31:0] KERNEL_VECTOR = 32'h8000_0180,
    parameter int          FLUSH_CYCLES  = 4,
    parameter int          ACK_TIMEOUT   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               cm_valid,
    input  logic [31:0]        cm_pc,
    input  logic               cm_tr,
    input  logic               cm_ovf,
    input  logic               cm_ri,
    input  logic               cm_sys,
    input  logic               cm_addrs,
    input  logic               cm_addrl,
    input  logic [31:0]        cm_badvaddr,
    input  logic               cm_eret,
    input  logic               ext_irq,
    exception_unit_if.master   cp0,
    output logic               flush,
    output logic               pc_redirect,
    output logic [31:0]        pc_target,
    output logic               busy,
    output logic               panic,
    output logic [2:0]         dbg_state
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RAISE      = 3'd1,
        FLUSH      = 3'd2,
        REDIRECT   = 3'd3,
        ERET_FLUSH = 3'd4,
        ERET_REDIR = 3'd5
    } state_e;

    state_e      state_q, state_d;
    logic        sync1_q, ext_s_q;
    logic [6:0]  cause_q, cause_d, cause_sel;
    logic [31:0] epc_q, epc_d, bad_q, bad_d, tgt_q, tgt_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        panic_q, panic_d;
    logic        any_flag, commit_ok, take;

    assign any_flag  = cm_tr | cm_ovf | cm_ri | cm_sys | cm_addrs | cm_addrl;
    assign commit_ok = ~stall & cm_valid;
    assign take      = commit_ok & ~cp0.exc_level & (ext_s_q | any_flag);

    // cause_sel bit order: {ext, tr, ovf, ri, sys, addrs, addrl}
    always_comb begin
        cause_sel = 7'b0;
        if (ext_s_q)       cause_sel = 7'b1000000;
        else if (cm_tr)    cause_sel = 7'b0100000;
        else if (cm_ovf)   cause_sel = 7'b0010000;
        else if (cm_ri)    cause_sel = 7'b0001000;
        else if (cm_sys)   cause_sel = 7'b0000100;
        else if (cm_addrs) cause_sel = 7'b0000010;
        else if (cm_addrl) cause_sel = 7'b0000001;
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        epc_d   = epc_q;
        bad_d   = bad_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        panic_d = panic_q;
        case (state_q)
            IDLE: begin
                if (take) begin
                    state_d = RAISE;
                    cause_d = cause_sel;
                    epc_d   = cm_pc;
                    bad_d   = (cause_sel[1] | cause_sel[0]) ? cm_badvaddr : 32'h0;
                    cnt_d   = 8'd0;
                end else if (commit_ok & cp0.exc_level & any_flag) begin
                    // Nested exception: record it, but never disturb the handler in flight.
                    panic_d = 1'b1;
                end else if (commit_ok & cm_eret) begin
                    state_d = ERET_FLUSH;
                end
            end
            RAISE: begin
                if (cp0.cop_reset) begin
                    state_d = FLUSH;
                    cnt_d   = 8'(FLUSH_CYCLES - 1);
                end else if (cnt_q == 8'(ACK_TIMEOUT - 1)) begin
                    state_d = FLUSH;
                    panic_d = 1'b1;
                    cnt_d   = 8'(FLUSH_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            FLUSH: begin
                if (cnt_q == 8'd0) state_d = REDIRECT;
                else               cnt_d   = cnt_q - 8'd1;
            end
            REDIRECT:   state_d = IDLE;
            ERET_FLUSH: begin
                tgt_d   = cp0.epc_in;
                state_d = ERET_REDIR;
            end
            ERET_REDIR: state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sync1_q <= 1'b0;
            ext_s_q <= 1'b0;
            cause_q <= 7'b0;
            epc_q   <= 32'h0;
            bad_q   <= 32'h0;
            tgt_q   <= 32'h0;
            cnt_q   <= 8'd0;
            panic_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= ext_irq;
            ext_s_q <= sync1_q;
            cause_q <= cause_d;
            epc_q   <= epc_d;
            bad_q   <= bad_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            panic_q <= panic_d;
        end
    end

    logic [6:0] int_vec;
    assign int_vec = (state_q == RAISE) ? cause_q : 7'b0;
    assign {cp0.int_ext, cp0.int_tr, cp0.int_ovf, cp0.int_ri,
            cp0.int_sys, cp0.int_addrs, cp0.int_addrl} = int_vec;
    assign cp0.epc_out      = epc_q;
    assign cp0.badvaddr_out = bad_q;

    assign flush       = (state_q == FLUSH) | (state_q == ERET_FLUSH);
    assign pc_redirect = (state_q == REDIRECT) | (state_q == ERET_REDIR);
    assign pc_target   = (state_q == REDIRECT)   ? KERNEL_VECTOR :
                         (state_q == ERET_REDIR) ? tgt_q : 32'h0;
    assign busy        = (state_q != IDLE);
    assign panic       = panic_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_exception_unit.sv
// Directed bench for exception_unit: cause priority, ack/timeout paths, ERET, nested panic, reset.
module tb_exception_unit;
    logic        clk = 1'b0;
    logic        reset, stall, cm_valid, cm_eret, ext_irq;
    logic [31:0] cm_pc, cm_badvaddr;
    logic        cm_tr, cm_ovf, cm_ri, cm_sys, cm_addrs, cm_addrl;
    logic        flush, pc_redirect, busy, panic;
    logic [31:0] pc_target;
    logic [2:0]  dbg_state;
    int          n_checks = 0;
    int          n_pass   = 0;

    localparam logic [31:0] KV = 32'h8000_0180;

    exception_unit_if cp0_bus ();

    exception_unit dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .cm_valid    (cm_valid),
        .cm_pc       (cm_pc),
        .cm_tr       (cm_tr),
        .cm_ovf      (cm_ovf),
        .cm_ri       (cm_ri),
        .cm_sys      (cm_sys),
        .cm_addrs    (cm_addrs),
        .cm_addrl    (cm_addrl),
        .cm_badvaddr (cm_badvaddr),
        .cm_eret     (cm_eret),
        .ext_irq     (ext_irq),
        .cp0         (cp0_bus.master),
        .flush       (flush),
        .pc_redirect (pc_redirect),
        .pc_target   (pc_target),
        .busy        (busy),
        .panic       (panic),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    // {ext, tr, ovf, ri, sys, addrs, addrl}
    logic [6:0] ints;
    assign ints = {cp0_bus.int_ext, cp0_bus.int_tr, cp0_bus.int_ovf, cp0_bus.int_ri,
                   cp0_bus.int_sys, cp0_bus.int_addrs, cp0_bus.int_addrl};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cm();
        cm_valid = 1'b0; cm_eret = 1'b0;
        cm_tr = 1'b0; cm_ovf = 1'b0; cm_ri = 1'b0;
        cm_sys = 1'b0; cm_addrs = 1'b0; cm_addrl = 1'b0;
        cm_pc = 32'h0; cm_badvaddr = 32'h0;
    endtask

    // Called in a RAISE cycle: ack, expect 4 flush cycles, kernel redirect, then idle.
    task automatic ack_and_drain(input string tag);
        cp0_bus.cop_reset = 1'b1;
        step();
        cp0_bus.cop_reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check({tag, "_flush"}, 32'(flush), 32'd1);
            step();
        end
        check({tag, "_redir"}, 32'(pc_redirect), 32'd1);
        check({tag, "_target"}, pc_target, KV);
        check({tag, "_redir_noflush"}, 32'(flush), 32'd0);
        step();
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        clear_cm();
        reset = 1'b1; stall = 1'b0; ext_irq = 1'b0;
        cp0_bus.cop_reset = 1'b0; cp0_bus.exc_level = 1'b0; cp0_bus.epc_in = 32'h0;
        step(); step();
        check("rst_flush", 32'(flush), 32'd0);
        check("rst_redir", 32'(pc_redirect), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_panic", 32'(panic), 32'd0);
        check("rst_ints", 32'(ints), 32'd0);
        check("rst_epc", cp0_bus.epc_out, 32'h0);
        check("rst_state", 32'(dbg_state), 32'd0);
        reset = 1'b0;
        step();

        // Overflow with ack after two RAISE cycles
        cm_valid = 1'b1; cm_ovf = 1'b1; cm_pc = 32'h0040_0020;
        step();
        clear_cm();
        check("ovf_int", 32'(ints), 32'h10);
        check("ovf_epc", cp0_bus.epc_out, 32'h0040_0020);
        check("ovf_busy", 32'(busy), 32'd1);
        step();
        check("ovf_hold", 32'(ints), 32'h10);
        ack_and_drain("ovf");
        check("ovf_ints_after", 32'(ints), 32'd0);

        // ri outranks addrl; BadVAddr only for address errors
        cm_valid = 1'b1; cm_ri = 1'b1; cm_addrl = 1'b1; cm_badvaddr = 32'h1001_0003;
        step();
        clear_cm();
        check("ri_int", 32'(ints), 32'h08);
        check("ri_bad", cp0_bus.badvaddr_out, 32'h0);
        ack_and_drain("ri");

        cm_valid = 1'b1; cm_addrl = 1'b1; cm_badvaddr = 32'h1001_0003;
        step();
        clear_cm();
        check("addrl_int", 32'(ints), 32'h01);
        check("addrl_bad", cp0_bus.badvaddr_out, 32'h1001_0003);
        ack_and_drain("addrl");

        // Stall suppresses the take
        stall = 1'b1; cm_valid = 1'b1; cm_tr = 1'b1;
        step();
        clear_cm(); stall = 1'b0;
        check("stall_busy", 32'(busy), 32'd0);

        // Nested exception with EXL set
        cp0_bus.exc_level = 1'b1; cm_valid = 1'b1; cm_sys = 1'b1;
        step();
        clear_cm(); cp0_bus.exc_level = 1'b0;
        check("exl_ints", 32'(ints), 32'd0);
        check("exl_flush", 32'(flush), 32'd0);
        check("exl_panic", 32'(panic), 32'd1);
        check("exl_busy", 32'(busy), 32'd0);
        step();
        check("exl_panic_sticky", 32'(panic), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("exl_panic_cleared", 32'(panic), 32'd0);

        // ERET
        cp0_bus.epc_in = 32'h0040_0104; cm_valid = 1'b1; cm_eret = 1'b1;
        step();
        clear_cm();
        check("eret_flush", 32'(flush), 32'd1);
        check("eret_ints", 32'(ints), 32'd0);
        check("eret_noredir", 32'(pc_redirect), 32'd0);
        step();
        check("eret_redir", 32'(pc_redirect), 32'd1);
        check("eret_target", pc_target, 32'h0040_0104);
        check("eret_noflush", 32'(flush), 32'd0);
        step();
        check("eret_idle", 32'(busy), 32'd0);

        // ERET together with a trap: the trap wins
        cm_valid = 1'b1; cm_eret = 1'b1; cm_tr = 1'b1; cm_pc = 32'h0040_0200;
        step();
        clear_cm();
        check("eret_tr_int", 32'(ints), 32'h20);
        check("eret_tr_epc", cp0_bus.epc_out, 32'h0040_0200);
        ack_and_drain("eret_tr");

        // No ack: 8 RAISE cycles then panic and flush
        cm_valid = 1'b1; cm_sys = 1'b1; cm_pc = 32'h0040_0300;
        step();
        clear_cm();
        for (int i = 0; i < 8; i++) begin
            check("to_raise", 32'(ints), 32'h04);
            check("to_nopanic", 32'(panic), 32'd0);
            step();
        end
        check("to_panic", 32'(panic), 32'd1);
        check("to_ints_off", 32'(ints), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("to_flush", 32'(flush), 32'd1);
            step();
        end
        check("to_redir", 32'(pc_redirect), 32'd1);
        check("to_target", pc_target, KV);
        step();
        check("to_idle", 32'(busy), 32'd0);

        // Reset in the 2nd FLUSH cycle, then a fresh external interrupt
        reset = 1'b1;
        step();
        reset = 1'b0;
        cm_valid = 1'b1; cm_ovf = 1'b1; cm_pc = 32'h0040_0400;
        step();
        clear_cm();
        cp0_bus.cop_reset = 1'b1;
        step();
        cp0_bus.cop_reset = 1'b0;
        check("rf_flush1", 32'(flush), 32'd1);
        step();
        check("rf_flush2", 32'(flush), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rf_flush", 32'(flush), 32'd0);
        check("rf_busy", 32'(busy), 32'd0);
        check("rf_panic", 32'(panic), 32'd0);
        cm_valid = 1'b1; ext_irq = 1'b1;
        step();
        check("irq_c1", 32'(busy), 32'd0);
        step();
        check("irq_c2", 32'(busy), 32'd0);
        step();
        check("irq_c3_int", 32'(ints), 32'h40);
        check("irq_c3_busy", 32'(busy), 32'd1);
        cm_valid = 1'b0; ext_irq = 1'b0;
        ack_and_drain("irq");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
